// File: rtl/csa_accum.sv
// csa_accum: accumulates groups of unsigned operands using a carry-save pair (ss, cc),
// resolves the pending carries after the last operand and presents the group sum
// modulo 2^ACCW with a sticky overflow flag on a valid/ready output.
module csa_accum #(
    parameter int unsigned OPW  = 4,
    parameter int unsigned ACCW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_sum,
    output logic            out_ovf
);

    typedef enum logic [1:0] {StAcc, StResolve, StOut} state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ACCW-1:0]   r_ss;
    logic [ACCW-1:0]   r_cc;
    logic              r_ovf;
    logic [ACCW-1:0]   w_ss_nxt;
    logic [ACCW-1:0]   w_cc_nxt;
    logic              w_ovf_nxt;

    logic [ACCW-1:0]   w_d;
    logic [ACCW-1:0]   w_maj;
    logic [ACCW-1:0]   w_and;

    assign w_d   = {{(ACCW-OPW){1'b0}}, in_data};
    // Full-adder carries of the 3:2 compression and half-adder carries of the resolve step.
    assign w_maj = (r_ss & r_cc) | (r_ss & w_d) | (r_cc & w_d);
    assign w_and = r_ss & r_cc;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StAcc;
            r_ss    <= '0;
            r_cc    <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ss    <= w_ss_nxt;
            r_cc    <= w_cc_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // Next-state logic: compress operands in ACC, ripple carries in RESOLVE, hold in OUT.
    always_comb begin
        w_state_nxt = r_state;
        w_ss_nxt    = r_ss;
        w_cc_nxt    = r_cc;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            StAcc: begin
                if (in_valid) begin
                    w_ss_nxt  = r_ss ^ r_cc ^ w_d;
                    w_cc_nxt  = {w_maj[ACCW-2:0], 1'b0};
                    // A carry leaving the MSB is worth 2^ACCW: the group has overflowed.
                    w_ovf_nxt = r_ovf | w_maj[ACCW-1];
                    if (in_last) begin
                        w_state_nxt = StResolve;
                    end
                end
            end
            StResolve: begin
                if (r_cc == '0) begin
                    w_state_nxt = StOut;
                end else begin
                    w_ss_nxt  = r_ss ^ r_cc;
                    w_cc_nxt  = {w_and[ACCW-2:0], 1'b0};
                    w_ovf_nxt = r_ovf | w_and[ACCW-1];
                end
            end
            StOut: begin
                if (out_ready) begin
                    w_state_nxt = StAcc;
                    w_ss_nxt    = '0;
                    w_cc_nxt    = '0;
                    w_ovf_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = StAcc;
            end
        endcase
    end

    // Handshake outputs depend on state only; result is forced to zero outside OUT.
    always_comb begin
        in_ready  = (r_state == StAcc);
        out_valid = (r_state == StOut);
        out_sum   = out_valid ? r_ss : '0;
        out_ovf   = out_valid ? r_ovf : 1'b0;
    end

endmodule
